// File: rtl/vending_machine.sv
// Ticket vending controller: choose stations, choose a ticket count, then pay with coins.
// Every output is registered. A session ends in DONE and only reset starts a new one.
module vending_machine (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] howManyTicket,
  input  logic [2:0]  origin,
  input  logic [2:0]  destination,
  input  logic [31:0] money,
  output logic [31:0] costOfTicket,
  output logic [31:0] moneyToPay,
  output logic [31:0] totalMoney,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TICKET = 2'd1,
    PAY    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  fare_q, fare_d;
  logic [31:0] cost_q, cost_d;
  logic [31:0] owe_q, owe_d;
  logic [31:0] total_q, total_d;

  logic [2:0]  diff;
  logic [3:0]  diff_p1;
  logic [5:0]  fare_calc;
  logic [9:0]  prod;
  logic [31:0] new_total;
  logic        stn_ok, cnt_ok, coin_ok;

  // A fare unit is the station distance plus one; 5 * n is built as 4n + n.
  assign diff      = (origin > destination) ? (origin - destination) : (destination - origin);
  assign diff_p1   = {1'b0, diff} + 4'd1;
  assign fare_calc = {diff_p1, 2'b00} + {2'b00, diff_p1};
  assign prod      = {4'b0000, fare_q} * {6'b000000, howManyTicket[3:0]};
  assign new_total = total_q + money;

  assign stn_ok  = (origin >= 3'd1) && (origin <= 3'd5) &&
                   (destination >= 3'd1) && (destination <= 3'd5);
  assign cnt_ok  = (howManyTicket >= 32'd1) && (howManyTicket <= 32'd15);
  assign coin_ok = (money == 32'd1) || (money == 32'd5) || (money == 32'd10) ||
                   (money == 32'd50) || (money == 32'd100);

  always_comb begin
    state_d = state_q;
    fare_d  = fare_q;
    cost_d  = cost_q;
    owe_d   = owe_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (stn_ok) begin
          fare_d  = fare_calc;
          state_d = TICKET;
        end
      end
      TICKET: begin
        if (cnt_ok) begin
          cost_d  = {22'd0, prod};
          owe_d   = {22'd0, prod};
          state_d = PAY;
        end
      end
      PAY: begin
        if (coin_ok) begin
          total_d = new_total;
          if (new_total >= cost_q) begin
            owe_d   = 32'd0;
            state_d = DONE;
          end else begin
            owe_d = cost_q - new_total;
          end
        end
      end
      default: ; // DONE holds everything until reset
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fare_q  <= 6'd0;
      cost_q  <= 32'd0;
      owe_q   <= 32'd0;
      total_q <= 32'd0;
    end else begin
      state_q <= state_d;
      fare_q  <= fare_d;
      cost_q  <= cost_d;
      owe_q   <= owe_d;
      total_q <= total_d;
    end
  end

  assign costOfTicket = cost_q;
  assign moneyToPay   = owe_q;
  assign totalMoney   = total_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: hand-computed fares, payments, rejects and resets.
module tb_vending_machine;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TICKET = 2'd1;
  localparam logic [1:0] S_PAY    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] howManyTicket;
  logic [2:0]  origin;
  logic [2:0]  destination;
  logic [31:0] money;
  logic [31:0] costOfTicket;
  logic [31:0] moneyToPay;
  logic [31:0] totalMoney;
  logic [1:0]  state_o;

  int vectors;
  int fails;

  vending_machine dut (
    .clk           (clk),
    .reset         (reset),
    .howManyTicket (howManyTicket),
    .origin        (origin),
    .destination   (destination),
    .money         (money),
    .costOfTicket  (costOfTicket),
    .moneyToPay    (moneyToPay),
    .totalMoney    (totalMoney),
    .state_o       (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks the three outputs and the state in one go.
  task automatic check_all(input string tag, input logic [31:0] c, input logic [31:0] m,
                           input logic [31:0] t, input logic [1:0] s);
    check({tag, ".cost"},  costOfTicket, c);
    check({tag, ".owe"},   moneyToPay,   m);
    check({tag, ".total"}, totalMoney,   t);
    check({tag, ".state"}, {30'd0, state_o}, {30'd0, s});
  endtask

  // One active edge, then settle at the falling edge where inputs are driven and outputs sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_all(tag, 32'd0, 32'd0, 32'd0, S_IDLE);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_inputs();
    origin = 3'd0; destination = 3'd0; howManyTicket = 32'd0; money = 32'd0;
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    reset   = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset("rst0");

    // 2 -> 5, two tickets, four 10-coins: fare 20, cost 40
    origin = 3'd2; destination = 3'd5;
    step();
    check_all("a_stn", 32'd0, 32'd0, 32'd0, S_TICKET);
    origin = 3'd0; destination = 3'd7;  // ignored outside IDLE
    howManyTicket = 32'd2;
    step();
    check_all("a_cnt", 32'd40, 32'd40, 32'd0, S_PAY);
    howManyTicket = 32'd9;              // ignored outside TICKET
    money = 32'd10;
    step(); check_all("a_c1", 32'd40, 32'd30, 32'd10, S_PAY);
    step(); check_all("a_c2", 32'd40, 32'd20, 32'd20, S_PAY);
    step(); check_all("a_c3", 32'd40, 32'd10, 32'd30, S_PAY);
    step(); check_all("a_c4", 32'd40, 32'd0,  32'd40, S_DONE);
    money = 32'd50;
    step(); check_all("a_done", 32'd40, 32'd0, 32'd40, S_DONE);
    step(); check_all("a_hold", 32'd40, 32'd0, 32'd40, S_DONE);
    clear_inputs();
    do_reset("rst_a");

    // 1 -> 5, three tickets: fare 25, cost 75; reset mid-payment
    origin = 3'd1; destination = 3'd5;
    step();
    check_all("b_stn", 32'd0, 32'd0, 32'd0, S_TICKET);
    howManyTicket = 32'd3;
    step();
    check_all("b_cnt", 32'd75, 32'd75, 32'd0, S_PAY);
    money = 32'd10;
    step(); check_all("b_c1", 32'd75, 32'd65, 32'd10, S_PAY);
    step(); check_all("b_c2", 32'd75, 32'd55, 32'd20, S_PAY);
    do_reset("b_rst");
    clear_inputs();
    step();
    check_all("b_after", 32'd0, 32'd0, 32'd0, S_IDLE);

    // 4 -> 1 (reversed order), two tickets: fare 20, cost 40; pay 10, 10, 50 -> change 30
    origin = 3'd4; destination = 3'd1;
    step();
    howManyTicket = 32'd2;
    step();
    check_all("c_cnt", 32'd40, 32'd40, 32'd0, S_PAY);
    money = 32'd10; step(); check_all("c_c1", 32'd40, 32'd30, 32'd10, S_PAY);
    money = 32'd10; step(); check_all("c_c2", 32'd40, 32'd20, 32'd20, S_PAY);
    money = 32'd50; step(); check_all("c_c3", 32'd40, 32'd0,  32'd70, S_DONE);
    check("c_change", totalMoney - costOfTicket, 32'd30);
    clear_inputs();
    do_reset("rst_c");

    // 3 -> 3: fare 5; counts 0 and 16 rejected, then 4 -> cost 20
    origin = 3'd3; destination = 3'd3;
    step();
    howManyTicket = 32'd0;
    step(); check_all("d_z1", 32'd0, 32'd0, 32'd0, S_TICKET);
    step(); check_all("d_z2", 32'd0, 32'd0, 32'd0, S_TICKET);
    step(); check_all("d_z3", 32'd0, 32'd0, 32'd0, S_TICKET);
    howManyTicket = 32'd16;
    step(); check_all("d_16", 32'd0, 32'd0, 32'd0, S_TICKET);
    howManyTicket = 32'd4;
    step(); check_all("d_cnt", 32'd20, 32'd20, 32'd0, S_PAY);

    // Non-coin values in PAY are ignored; held coins count every edge
    money = 32'd7;
    step(); check_all("e_m7a", 32'd20, 32'd20, 32'd0, S_PAY);
    step(); check_all("e_m7b", 32'd20, 32'd20, 32'd0, S_PAY);
    money = 32'd0;
    step(); check_all("e_m0a", 32'd20, 32'd20, 32'd0, S_PAY);
    step(); check_all("e_m0b", 32'd20, 32'd20, 32'd0, S_PAY);
    money = 32'd1;
    step(); check_all("e_m1", 32'd20, 32'd19, 32'd1, S_PAY);
    money = 32'd5;
    step(); check_all("e_m5a", 32'd20, 32'd14, 32'd6, S_PAY);
    step(); check_all("e_m5b", 32'd20, 32'd9,  32'd11, S_PAY);
    money = 32'd100;
    step(); check_all("e_m100", 32'd20, 32'd0, 32'd111, S_DONE);
    clear_inputs();
    do_reset("rst_e");

    // Invalid stations keep the machine in IDLE
    origin = 3'd0; destination = 3'd3;
    step(); check_all("f_o0", 32'd0, 32'd0, 32'd0, S_IDLE);
    origin = 3'd2; destination = 3'd6;
    step(); check_all("f_d6", 32'd0, 32'd0, 32'd0, S_IDLE);
    origin = 3'd5; destination = 3'd1;
    step(); check_all("f_ok", 32'd0, 32'd0, 32'd0, S_TICKET);
    howManyTicket = 32'd15;  // fare 25 x 15 = 375, largest legal order
    step(); check_all("f_max", 32'd375, 32'd375, 32'd0, S_PAY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state.
REQ-004 howManyTicket  input  32  requested ticket count, unsigned.
REQ-005 origin  input  3  origin station, valid 1..5.
REQ-006 destination  input  3  destination station, valid 1..5.
REQ-007 money  input  32  coin value presented this cycle; 0 = no coin.
REQ-008 costOfTicket  output  32  total price = fare x ticket count.
REQ-009 moneyToPay  output  32  amount still owed.
REQ-010 totalMoney  output  32  cumulative accepted money.

Function
REQ-011 Fare SHALL be 5 x (|origin - destination| + 1), giving 5..25; origin equal to destination costs 5.
REQ-012 The FSM SHALL have four states: IDLE, TICKET, PAY and DONE; all outputs SHALL be registered.
REQ-013 IDLE SHALL move to TICKET on a clk edge where origin and destination are both in 1..5, and SHALL latch the fare on that edge; otherwise it SHALL stay in IDLE.
REQ-014 TICKET SHALL move to PAY on a clk edge where howManyTicket is in 1..15, and SHALL load costOfTicket = fare x howManyTicket and moneyToPay = costOfTicket on that edge.
REQ-015 In TICKET, a howManyTicket of 0 or greater than 15 SHALL be ignored, and the FSM SHALL stay in TICKET.
REQ-016 In PAY, every clk edge SHALL sample money; the values 1, 5, 10, 50 and 100 are accepted coins; any other value, including 0, SHALL be ignored.
REQ-017 The same value held on money over N edges SHALL count as N coins; there is no edge detection.
REQ-018 On an accepted coin, totalMoney SHALL become totalMoney + money.
REQ-019 On an accepted coin, moneyToPay SHALL become costOfTicket minus the new total, saturating at 0.
REQ-020 When the new total is greater than or equal to costOfTicket, the FSM SHALL enter DONE on the same edge.
REQ-021 DONE SHALL hold all outputs; change is totalMoney - costOfTicket; further money is ignored; DONE is left only by reset.
REQ-022 origin and destination SHALL be ignored outside IDLE, and howManyTicket SHALL be ignored outside TICKET.
REQ-023 All arithmetic SHALL be 32-bit unsigned; no overflow handling is required below 2^31.
REQ-024 Outputs SHALL change only on a clk edge, or asynchronously on reset assertion.

Reset
REQ-025 While reset = 0, the state SHALL be IDLE and costOfTicket, moneyToPay and totalMoney SHALL be 0, independent of clk.
REQ-026 Asserting reset in any state, including mid-payment, SHALL discard the transaction; inserted money is not retained.
REQ-027 The first clk edge after reset returns to 1 SHALL be evaluated as IDLE.

Verification
REQ-028 origin=2, destination=5, howManyTicket=2, money=10 for 4 edges -> costOfTicket=40; moneyToPay 40/30/20/10/0; totalMoney 0/10/20/30/40; DONE.
REQ-029 origin=1, destination=5, howManyTicket=3, money=10 for 2 edges, then reset=0 -> costOfTicket=75, totalMoney=20, moneyToPay=55 before reset; all outputs 0 after reset.
REQ-030 origin=1, destination=4, howManyTicket=2, money 10, 10, 50 -> costOfTicket=40, totalMoney=70, moneyToPay=0, DONE; change is 30.
REQ-031 origin=3, destination=3, howManyTicket=0 for 3 edges, then 4 -> stays in TICKET while the count is 0, then costOfTicket=20.
REQ-032 In PAY, money=7 or money=0 for 2 edges -> totalMoney and moneyToPay unchanged.
REQ-033 origin=0 or destination=6 -> stays in IDLE with outputs 0; in DONE, money=50 -> totalMoney unchanged.
